// File: rtl/servo_pkg.sv
// Shared types and default constants for the servo PWM generator.
// Holds the FSM state enum and the default parameter values.
package servo_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW
    } state_t;

    localparam int unsigned DEF_PERIOD_TICKS = 1000;
    localparam int unsigned DEF_MIN_TICKS    = 50;
    localparam int unsigned DEF_MAX_TICKS    = 100;
    localparam int unsigned DEF_POS_W        = 8;

endpackage

// File: rtl/servo_pwm_tick_sync.sv
// Two-flop synchronizer plus rising-edge detect for the a_PWM tick source.
// Ports: clk, rst (async active-low), a_i (async level), tick_o (1-clk pulse).
module tick_sync (
    input  logic clk,
    input  logic rst,
    input  logic a_i,
    output logic tick_o
);

    // [0],[1] synchronize; [2] holds the previous synced value
    logic [2:0] sync_q;
    logic       tick_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            tick_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], a_i};
            // registered so the pulse lands 3 clk after the a_i rise
            tick_q <= sync_q[1] & ~sync_q[2];
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/servo_pwm.sv
// Servo PWM: frames of PERIOD_TICKS ticks, pulse width MIN_TICKS+pos ticks.
// Ports: clk, rst (async active-low), a_PWM (tick source, sampled as data),
//   enable, pos/pos_valid/pos_ready (one-deep shadow handshake),
//   pwm_out, frame_start (1-clk pulse), busy (FSM not idle).
// Build option: define SERVO_CLAMP_EN to clamp loaded widths to MAX_TICKS.
module servo_pwm
    import servo_pkg::*;
#(
    parameter int unsigned PERIOD_TICKS = DEF_PERIOD_TICKS,
    parameter int unsigned MIN_TICKS    = DEF_MIN_TICKS,
    parameter int unsigned MAX_TICKS    = DEF_MAX_TICKS,
    parameter int unsigned POS_W        = DEF_POS_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_PWM,
    input  logic             enable,
    input  logic [POS_W-1:0] pos,
    input  logic             pos_valid,
    output logic             pos_ready,
    output logic             pwm_out,
    output logic             frame_start,
    output logic             busy
);

    // wide enough for MIN+pos, the clamp limit and the frame counter
    localparam int unsigned WW =
        $clog2(MIN_TICKS + 2**POS_W + PERIOD_TICKS + MAX_TICKS + 1);

    typedef logic [WW-1:0] ticks_t;

    localparam ticks_t RST_WIDTH = ticks_t'(MIN_TICKS + 2**(POS_W-1));
    localparam ticks_t LAST_CNT  = ticks_t'(PERIOD_TICKS - 1);

    function automatic ticks_t calc_width(input logic [POS_W-1:0] p);
        ticks_t w;
        w = ticks_t'(MIN_TICKS) + ticks_t'(p);
`ifdef SERVO_CLAMP_EN
        if (w > ticks_t'(MAX_TICKS)) begin
            w = ticks_t'(MAX_TICKS);
        end
`endif
        return w;
    endfunction

    logic tick;

    tick_sync u_tick_sync (
        .clk    (clk),
        .rst    (rst),
        .a_i    (a_PWM),
        .tick_o (tick)
    );

    state_t           state_q, state_d;
    ticks_t           cnt_q, cnt_d;
    ticks_t           width_q, width_d;
    logic [POS_W-1:0] shadow_q, shadow_d;
    logic             full_q, full_d;
    logic             pwm_q, pwm_d;
    logic             fs_q, fs_d;
    logic             xfer;
    logic             start;
    ticks_t           cnt_inc;
    ticks_t           wnew;

    assign xfer    = pos_valid & ~full_q;
    assign cnt_inc = cnt_q + ticks_t'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            width_q  <= RST_WIDTH;
            shadow_q <= '0;
            full_q   <= 1'b0;
            pwm_q    <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            width_q  <= width_d;
            shadow_q <= shadow_d;
            full_q   <= full_d;
            pwm_q    <= pwm_d;
            fs_q     <= fs_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        width_d  = width_q;
        shadow_d = shadow_q;
        full_d   = full_q;
        pwm_d    = pwm_q;
        fs_d     = 1'b0;
        start    = 1'b0;
        wnew     = width_q;

        if (xfer) begin
            shadow_d = pos;
            full_d   = 1'b1;
        end

        if (tick) begin
            unique case (state_q)
                S_IDLE: start = enable;
                S_HIGH, S_LOW: begin
                    if (cnt_q == LAST_CNT) begin
                        // enable is only sampled here, so frames never truncate
                        if (enable) begin
                            start = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                            pwm_d   = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                        if (state_q == S_HIGH && cnt_inc == width_q) begin
                            state_d = S_LOW;
                            pwm_d   = 1'b0;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (start) begin
            // xfer needs an empty shadow, so a full shadow always drains here
            if (full_q) begin
                wnew   = calc_width(shadow_q);
                full_d = 1'b0;
            end
            width_d = wnew;
            cnt_d   = '0;
            fs_d    = 1'b1;
            pwm_d   = (wnew != '0);
            state_d = (wnew != '0) ? S_HIGH : S_LOW;
        end
    end

    assign pos_ready   = ~full_q;
    assign pwm_out     = pwm_q;
    assign frame_start = fs_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_servo_pwm.sv
// Scoreboard bench for servo_pwm: expected pulse widths are queued by the
// stimulus, and a monitor measures each completed frame against them.
module tb_servo_pwm;

    localparam int TCLK = 8;
    localparam int FRAME_CLK = 20 * TCLK;
`ifdef SERVO_CLAMP_EN
    localparam int W15 = 8;
`else
    localparam int W15 = 17;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       a_PWM = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] pos = '0;
    logic       pos_valid = 1'b0;
    logic       pos_ready;
    logic       pwm_out;
    logic       frame_start;
    logic       busy;

    servo_pwm #(
        .PERIOD_TICKS (20),
        .MIN_TICKS    (2),
        .MAX_TICKS    (8),
        .POS_W        (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .a_PWM       (a_PWM),
        .enable      (enable),
        .pos         (pos),
        .pos_valid   (pos_valid),
        .pos_ready   (pos_ready),
        .pwm_out     (pwm_out),
        .frame_start (frame_start),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // a_PWM period of 8 clk, edges away from clk edges
    initial begin
        #2;
        forever begin
            #40 a_PWM = ~a_PWM;
        end
    end

    int errors = 0;
    int checks = 0;
    int frames = 0;
    int exp_q[$];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // monitor: one frame spans frame_start to next frame_start or idle
    int  hi = 0;
    int  len = 0;
    bit  in_frame = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            in_frame = 1'b0;
        end else begin
            if (in_frame && (frame_start || !busy)) begin
                frames++;
                in_frame = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_unexpected: got high %0d clk", hi);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    chk("frame_high_clk", hi, e * TCLK);
                    chk("frame_len_clk", len, FRAME_CLK);
                end
            end
            if (frame_start) begin
                in_frame = 1'b1;
                hi = 0;
                len = 0;
            end
            if (in_frame) begin
                len++;
                if (pwm_out) hi++;
            end
        end
    end

    task automatic wait_fs();
        int n;
        for (n = 0; n < 400; n++) begin
            @(negedge clk);
            if (frame_start) break;
        end
        if (n >= 400) fail("frame_start_timeout");
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 400; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (n >= 400) fail("idle_timeout");
    endtask

    task automatic send(input logic [3:0] p);
        int  n;
        bit  r;
        pos = p;
        pos_valid = 1'b1;
        for (n = 0; n < 400; n++) begin
            r = pos_ready;
            @(posedge clk);
            if (r) break;
            @(negedge clk);
        end
        if (n >= 400) fail("send_timeout");
        #1 pos_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_pos_ready", pos_ready, 1);
        chk("rst_pwm_out", pwm_out, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_busy", busy, 0);

        rst = 1'b1;
        enable = 1'b1;
        exp_q.push_back(10);
        exp_q.push_back(10);
        exp_q.push_back(10);
        exp_q.push_back(5);

        wait_fs();
        chk("first_frame_pwm", pwm_out, 1);
        chk("first_frame_busy", busy, 1);
        wait_fs();
        wait_fs();
        repeat (40) @(negedge clk);
        send(4'd3);
        chk("ready_after_xfer", pos_ready, 0);
        repeat (40) @(negedge clk);
        chk("ready_held_low", pos_ready, 0);
        wait_fs();
        chk("ready_at_load", pos_ready, 1);

        repeat (40) @(negedge clk);
        send(4'd15);
        exp_q.push_back(W15);
        wait_fs();

        repeat (40) @(negedge clk);
        send(4'd4);
        exp_q.push_back(6);
        exp_q.push_back(7);
        repeat (8) @(negedge clk);
        pos = 4'd5;
        pos_valid = 1'b1;
        wait_fs();
        @(negedge clk);
        pos_valid = 1'b0;
        chk("ready_after_start_xfer", pos_ready, 0);

        wait_fs();
        repeat (3 * TCLK) @(negedge clk);
        enable = 1'b0;
        chk("busy_after_enable_drop", busy, 1);
        wait_idle();
        chk("idle_pwm_out", pwm_out, 0);
        chk("idle_busy", busy, 0);
        repeat (200) @(negedge clk);
        chk("idle_frames", frames, 7);
        chk("idle_queue", exp_q.size(), 0);

        enable = 1'b1;
        wait_fs();
        repeat (16) @(negedge clk);
        chk("pre_rst_pwm_out", pwm_out, 1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_pwm_out", pwm_out, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_ready", pos_ready, 1);
        repeat (3) @(negedge clk);
        #3 rst = 1'b1;
        exp_q.push_back(10);
        exp_q.push_back(10);
        wait_fs();
        wait_fs();
        enable = 1'b0;
        wait_idle();
        @(negedge clk);
        chk("final_frames", frames, 9);
        chk("final_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/servo_pwm.md
SERVO_PWM -- requirements
Module: servo_pwm

Interface
REQ-001 Parameter PERIOD_TICKS, default 1000, frame length in ticks.
REQ-002 Parameter MIN_TICKS, default 50, pulse width for position 0.
REQ-003 Parameter MAX_TICKS, default 100, upper pulse-width limit, used when clamping is enabled.
REQ-004 Parameter POS_W, default 8, position word width.
REQ-005 Port clk, input, 1, sole system clock.
REQ-006 Port rst, input, 1, asynchronous active-low reset.
REQ-007 Port a_PWM, input, 1, divided-clock tick source from the frequency divider; treated as data, never as a clock.
REQ-008 Port enable, input, 1, run request.
REQ-009 Port pos, input, POS_W, requested position.
REQ-010 Port pos_valid, input, 1, pos is valid.
REQ-011 Port pos_ready, output, 1, one-deep shadow buffer can accept a position.
REQ-012 Port pwm_out, output, 1, servo drive pulse.
REQ-013 Port frame_start, output, 1, one-clk pulse at each frame start.
REQ-014 Port busy, output, 1, high whenever the FSM is not IDLE.

Function
REQ-015 a_PWM SHALL pass through a 2-FF synchronizer plus rising-edge detect; tick is a one-clk pulse asserted 3 clk after the a_PWM rise.
REQ-016 The FSM SHALL have states IDLE, HIGH, LOW; all counting advances only on tick.
REQ-017 IDLE->HIGH on tick with enable=1: cnt<=0, width<=load value, frame_start pulses, pwm_out=1.
REQ-018 On each tick in HIGH/LOW, cnt SHALL increment; HIGH->LOW when the incremented cnt equals width, giving exactly width ticks high.
REQ-019 On the tick where cnt=PERIOD_TICKS-1, cnt SHALL wrap to 0; if enable=1 a new frame starts (REQ-017); otherwise the FSM enters IDLE with pwm_out=0.
REQ-020 Deasserting enable mid-frame SHALL NOT truncate the current pulse or frame (no runt pulses).
REQ-021 width = MIN_TICKS + pos, computed at a width sufficient to avoid overflow.
REQ-022 width=0: pwm_out SHALL stay low the whole frame (HIGH skipped).
REQ-023 width>=PERIOD_TICKS: pwm_out SHALL stay high the whole frame.
REQ-024 Handshake: a transfer occurs on clk with pos_valid & pos_ready and sets shadow_full; pos_ready = ~shadow_full.
REQ-025 At frame start, if shadow_full, width SHALL load from the shadow and clear shadow_full; otherwise width is retained.
REQ-026 A transfer coinciding with a frame start SHALL load the old shadow into width, store the new value, and leave shadow_full=1.

Reset
REQ-027 rst=0 SHALL asynchronously force: state IDLE, cnt=0, shadow_full=0, pos_ready=1, pwm_out=0, frame_start=0, busy=0, synchronizer flops=0, width=MIN_TICKS+2^(POS_W-1).
REQ-028 Reset mid-pulse SHALL drop pwm_out immediately; after release, the first frame starts on the first tick with enable=1.

Configuration
REQ-029 With SERVO_CLAMP_EN defined, the loaded width SHALL be min(MIN_TICKS+pos, MAX_TICKS).
REQ-030 Without SERVO_CLAMP_EN, no clamping SHALL occur and MAX_TICKS is unused.

Structure
REQ-031 Package servo_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-032 Sub-module tick_sync (synchronizer plus edge detect, output tick) SHALL be instantiated once.

Verification (bench: PERIOD_TICKS=20, MIN_TICKS=2, MAX_TICKS=8, POS_W=4, a_PWM period 8 clk)
REQ-033 Reset release, enable=1, no pos -> pwm_out high 10 ticks, low 10 ticks, frame_start every 20 ticks.
REQ-034 pos=3 accepted mid-frame -> current frame unchanged; next frame high exactly 5 ticks; pos_ready low until that frame start.
REQ-035 pos=15, SERVO_CLAMP_EN defined -> high 8 ticks; macro undefined -> high 17 ticks.
REQ-036 enable dropped at tick 3 of a frame -> full pulse and frame complete, then IDLE, busy=0, pwm_out=0.
REQ-037 pos_valid asserted on the frame-start clk with the shadow holding 4 -> width=6 this frame, the new value is used next frame, and pos_ready stays 0.
REQ-038 rst asserted during HIGH -> pwm_out=0 within the same clk, width=10 after release.
